// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with optional early-out.
module ex_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      muldiv_op,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d, state_nxt_s;
    logic [4:0]          cnt_q, cnt_d, cnt_nxt_s;
    logic [2:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic                b_zero_q, b_zero_d;
    logic [XLEN-1:0]     a_abs_q, a_abs_d, b_abs_q, b_abs_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d, result_nxt_s;
    logic                done_q, done_d, busy_q, busy_d;

    logic                signed_a_s, signed_b_s, sa_s, sb_s;
    logic [XLEN-1:0]     a_abs_s, b_abs_s;
    logic                early_zero_s, early_ovf_s;
    logic [XLEN-1:0]     early_res_s;
    logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic                div_ge_s;
    logic [2*XLEN-1:0]   mul_acc_s, div_acc_s, prod_s;
    logic [XLEN-1:0]     div_rem_s, quo_fix_s, rem_fix_s, fix_res_s;

    // Operand decode: signedness per op, magnitudes and early-out detection.
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (muldiv_op)
            3'b001, 3'b100, 3'b110: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            3'b010:  signed_a_s = 1'b1;
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        sa_s         = signed_a_s & opr_a[XLEN-1];
        sb_s         = signed_b_s & opr_b[XLEN-1];
        a_abs_s      = sa_s ? ({XLEN{1'b0}} - opr_a) : opr_a;
        b_abs_s      = sb_s ? ({XLEN{1'b0}} - opr_b) : opr_b;
        early_zero_s = muldiv_op[2] & (opr_b == {XLEN{1'b0}});
        early_ovf_s  = muldiv_op[2] & ~muldiv_op[0]
                       & (opr_a == {1'b1, {(XLEN-1){1'b0}}}) & (opr_b == {XLEN{1'b1}});
        if (muldiv_op[1]) begin
            early_res_s = early_zero_s ? opr_a : {XLEN{1'b0}};
        end else begin
            early_res_s = early_zero_s ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_abs_q} : {(XLEN+1){1'b0}});
        mul_acc_s   = {mul_sum_s, acc_q[XLEN-1:1]};
        div_shift_s = {rem_q, acc_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_abs_q};
        div_ge_s    = (div_shift_s >= {1'b0, b_abs_q});
        div_rem_s   = div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
        div_acc_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge_s};
        prod_s      = (sign_a_q ^ sign_b_q) ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
        quo_fix_s   = ((sign_a_q ^ sign_b_q) & ~b_zero_q) ? ({XLEN{1'b0}} - acc_q[XLEN-1:0])
                                                          : acc_q[XLEN-1:0];
        rem_fix_s   = sign_a_q ? ({XLEN{1'b0}} - rem_q) : rem_q;
        case (op_q)
            3'b000:                 fix_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = quo_fix_s;
            3'b110, 3'b111:         fix_res_s = rem_fix_s;
            default:                fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_nxt_s  = state_q;
        cnt_nxt_s    = cnt_q;
        result_nxt_s = result_q;
        op_d         = op_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        b_zero_d     = b_zero_q;
        a_abs_d      = a_abs_q;
        b_abs_d      = b_abs_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = muldiv_op;
                    sign_a_d  = sa_s;
                    sign_b_d  = sb_s;
                    b_zero_d  = (opr_b == {XLEN{1'b0}});
                    a_abs_d   = a_abs_s;
                    b_abs_d   = b_abs_s;
                    cnt_nxt_s = 5'd0;
                    rem_d     = {XLEN{1'b0}};
                    acc_d     = {{XLEN{1'b0}}, (muldiv_op[2] ? a_abs_s : b_abs_s)};
                    if (EARLY_OUT && (early_zero_s || early_ovf_s)) begin
                        result_nxt_s = early_res_s;
                        state_nxt_s  = S_DONE;
                    end else begin
                        state_nxt_s  = S_CALC;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d     = op_q[2] ? div_acc_s : mul_acc_s;
                rem_d     = op_q[2] ? div_rem_s : rem_q;
                cnt_nxt_s = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_FIX: begin
                result_nxt_s = fix_res_s;
                state_nxt_s  = S_DONE;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
        state_d  = flush ? S_IDLE : state_nxt_s;
        cnt_d    = flush ? 5'd0 : cnt_nxt_s;
        result_d = flush ? result_q : result_nxt_s;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_abs_q  <= {XLEN{1'b0}};
            b_abs_q  <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            rem_q    <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            a_abs_q  <= a_abs_d;
            b_abs_q  <= b_abs_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q & ~flush;
    assign result = result_q;
    assign stall  = start & ~done & ~flush;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: one instance with early-out, one without.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, start1, start0;
    logic [2:0]  muldiv_op;
    logic [31:0] opr_a, opr_b;
    logic        busy1, done1, stall1, busy0, done0, stall0;
    logic [31:0] result1, result0;

    int checks = 0;
    int errors = 0;
    bit sel = 1'b1;
    logic [31:0] last_res1 = 32'd0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .muldiv_op(muldiv_op),
        .opr_a(opr_a), .opr_b(opr_b), .flush(flush),
        .busy(busy1), .done(done1), .result(result1), .stall(stall1)
    );

    ex_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .muldiv_op(muldiv_op),
        .opr_a(opr_a), .opr_b(opr_b), .flush(flush),
        .busy(busy0), .done(done0), .result(result0), .stall(stall0)
    );

    wire        sel_done   = sel ? done1 : done0;
    wire        sel_stall  = sel ? stall1 : stall0;
    wire [31:0] sel_result = sel ? result1 : result0;

    typedef struct {
        bit          eo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Caller enters just after a rising edge; returns just after a rising edge.
    task automatic run_op(input bit eo, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                          input string nm);
        int cyc = 0;
        bit seen = 1'b0;
        bit stall_bad = 1'b0;
        logic [31:0] got = 32'd0;
        sel = eo;
        muldiv_op = op;
        opr_a = a;
        opr_b = b;
        if (eo) start1 = 1'b1; else start0 = 1'b1;
        while (!seen && cyc < 100) begin
            #2;
            if (sel_done === 1'b1) begin
                seen = 1'b1;
                got = sel_result;
                if (sel_stall !== 1'b0) stall_bad = 1'b1;
            end else if (sel_stall !== 1'b1) begin
                stall_bad = 1'b1;
            end
            @(posedge clk); #1;
            if (!seen) begin
                cyc++;
                opr_a = $urandom;
                opr_b = $urandom;
                muldiv_op = 3'($urandom_range(0, 7));
            end
        end
        start1 = 1'b0;
        start0 = 1'b0;
        chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_result"}, got, exp);
        chk({nm, "_done_cycle"}, cyc, exp_cyc);
        chk({nm, "_stall"}, {31'd0, stall_bad}, 32'd0);
        #2;
        chk({nm, "_result_held"}, sel_result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        bit bad;
        int d1, d2;
        logic [31:0] r1, r2;
        int npulse;

        // eo, op, a, b, expected, done cycle
        vecs.push_back('{1'b1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{1'b1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{1'b1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{1'b1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{1'b1, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b1, 3'b101, 32'd100,      32'd7,        32'd14,       34});
        vecs.push_back('{1'b1, 3'b111, 32'd100,      32'd7,        32'd2,        34});
        vecs.push_back('{1'b1, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{1'b1, 3'b111, 32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{1'b1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{1'b1, 3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{1'b0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b0, 3'b111, 32'd5,        32'd0,        32'd5,        34});
        vecs.push_back('{1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34});
        vecs.push_back('{1'b0, 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 34});
        vecs.push_back('{1'b0, 3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 34});
        vecs.push_back('{1'b0, 3'b000, 32'h12345678, 32'h00010000, 32'h56780000, 34});
        vecs.push_back('{1'b1, 3'b101, 32'd1000,     32'd10,       32'd100,      34});

        rst = 1'b1; flush = 1'b0; start1 = 1'b0; start0 = 1'b0;
        muldiv_op = 3'd0; opr_a = 32'd0; opr_b = 32'd0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        #2;
        chk("reset_result1", result1, 32'd0);
        chk("reset_result0", result0, 32'd0);
        chk("reset_busy_done", {28'd0, busy1, done1, busy0, done0}, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].eo, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].cyc,
                   $sformatf("vec%0d", i));
            if (vecs[i].eo) last_res1 = vecs[i].exp;
        end

        // flush coincident with start in IDLE: op must not be accepted
        sel = 1'b1; muldiv_op = 3'b000; opr_a = 32'd3; opr_b = 32'd3;
        start1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; flush = 1'b0;
        #2;
        chk("flush_start_busy", {31'd0, busy1}, 32'd0);
        @(posedge clk); #1;

        // flush at cycle 10 of a divide
        muldiv_op = 3'b101; opr_a = 32'd100; opr_b = 32'd7; start1 = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2; if (done1 !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        #1;
        chk("flush_busy_before", {31'd0, busy1}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall1}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; start1 = 1'b0;
        #2;
        chk("flush_busy_after", {31'd0, busy1}, 32'd0);
        chk("flush_result_kept", result1, last_res1);
        for (int c = 0; c < 40; c++) begin
            if (done1 !== 1'b0) bad = 1'b1;
            @(posedge clk); #3;
        end
        chk("flush_no_done", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        run_op(1'b1, 3'b000, 32'd3, 32'd4, 32'd12, 34, "post_flush_mul");

        // reset in the middle of CALC
        sel = 1'b1; muldiv_op = 3'b000; opr_a = 32'd9; opr_b = 32'd9; start1 = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start1 = 1'b0;
        #2;
        chk("midrst_busy_done", {30'd0, busy1, done1}, 32'd0);
        chk("midrst_result", result1, 32'd0);
        @(posedge clk); #1;

        // back-to-back multiplies: done pulses 35 cycles apart
        muldiv_op = 3'b000; opr_a = 32'd2; opr_b = 32'd3; start1 = 1'b1;
        cyc = 0; npulse = 0; d1 = -1; d2 = -1; r1 = 32'd0; r2 = 32'd0;
        while (npulse < 2 && cyc < 120) begin
            #2;
            if (done1 === 1'b1) begin
                if (npulse == 0) begin d1 = cyc; r1 = result1; end
                else begin d2 = cyc; r2 = result1; end
                npulse++;
            end
            @(posedge clk); #1;
            if (npulse == 1 && d1 == cyc) begin opr_a = 32'd4; opr_b = 32'd5; end
            cyc++;
        end
        start1 = 1'b0;
        chk("b2b_first_cycle", d1, 34);
        chk("b2b_second_cycle", d2, 69);
        chk("b2b_first_result", r1, 32'd6);
        chk("b2b_second_result", r2, 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit inside the execute stage, directly upstream of the memory stage. It computes all eight M-extension operations over multiple cycles and stalls the front of the pipeline while busy. Its result drives the ALU/result mux that feeds opr_res of the memory stage input bundle.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow complete in 1 cycle; when 0 they take full latency with identical results.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  M-extension instruction present in EX (held until done)
muldiv_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opr_a  in  XLEN  rs1 value (after forwarding)
opr_b  in  XLEN  rs2 value (after forwarding)
flush  in  1  kill in-flight op (branch mispredict/trap)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, result valid
result  out  XLEN  operation result, held until next accepted start
stall  out  1  combinational: start & ~done & ~flush

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset/flush (sync, priority: rst > flush > all): state=IDLE, counter=0, busy=0, done=0, result=0 (flush leaves result unchanged); no done pulse for the killed op.
- IDLE: start=1 latches op, |a|, |b|, sign flags, counter=0 -> CALC. Sign flags: MULH/DIV/REM both operands signed; MULHSU only opr_a signed; others unsigned.
- Early-out (EARLY_OUT=1, in IDLE): DIV/DIVU with opr_b=0 -> result=all ones; REM/REMU with opr_b=0 -> result=opr_a; DIV with opr_a=0x80000000, opr_b=0xFFFFFFFF -> result=0x80000000; REM same operands -> 0. Go straight to DONE.
- CALC, 32 cycles (counter 0..31): multiply = radix-2 shift-add into 64-bit accumulator; divide = restoring, 1 quotient bit/cycle, 33-bit partial remainder. counter==31 -> FIX.
- FIX (1 cycle): negate product if sign_a^sign_b; quotient negated if sign_a^sign_b; remainder takes sign of dividend. Select MUL=prod[31:0], MULH*=prod[63:32], DIV*=quotient, REM*=remainder. Register result -> DONE.
- DONE (1 cycle): done=1, stall=0, pipeline advances; start ignored this cycle -> IDLE.
- Latency: start sampled at edge 0; done high during cycle 34 (CALC 1..32, FIX 33). Early-out: done during cycle 1.
- Back-to-back: new start accepted in IDLE the cycle after DONE; no bubble beyond the DONE->IDLE cycle.
- Inputs opr_a/opr_b/muldiv_op are only sampled in IDLE; changes later are ignored.
- flush coincident with start in IDLE: start not accepted.
- flush in DONE: done still deasserted (flush wins); state -> IDLE.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done in cycle 34, stall=1 cycles 0..33, stall=0 in 34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- EARLY_OUT=1: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; each done in cycle 1. Repeat with EARLY_OUT=0 -> same values, done in cycle 34.
- flush at cycle 10 of a DIV -> busy=0 next cycle, no done pulse, result unchanged. Next start (MUL 3x4) -> 12 in 34 cycles.
- rst asserted mid-CALC -> next cycle busy=0, done=0, result=0. Two consecutive MULs (2x3, 4x5) -> done pulses 35 cycles apart with results 6 then 20.
